nexi_uart_tx_sched: RTL and testbench
=====================================

// Module: nexi_uart_tx_sched
// PURPOSE
//  Wishbone master sitting in front of the nexi UART wishbone slave. Arbitrates round-robin between
//  NUM_REQ byte producers and hands each byte to the UART: THR write, wait for TX IRQ, read ISR to clear.
//  Enables the TX interrupt once after reset. Exactly one byte is in flight at a time.
// PARAMETERS
//  NUM_REQ      2       number of byte requesters (1..8)
//  TIMEOUT_CYC  65535   max cycles in S_WAIT_IRQ before forced ISR read (>=1)
// PORTS
//  clk_i        in   1          system clock; one clock domain, all logic on posedge
//  rst_ni       in   1          asynchronous, active-low reset
//  req_valid_i  in   NUM_REQ    requester k has a byte on req_data_i[8k+7:8k]
//  req_data_i   in   8*NUM_REQ  packed request bytes
//  req_ready_o  out  NUM_REQ    one-hot 1-cycle pulse: byte of requester k accepted (THR write acked)
//  wb_cyc_o     out  1          wishbone cycle
//  wb_stb_o     out  1          wishbone strobe (always equal to wb_cyc_o)
//  wb_we_o      out  1          1 = write
//  wb_addr_o    out  3          1=THR, 2=IER, 3=ISR
//  wb_data_o    out  8          write data
//  wb_data_i    in   8          read data
//  wb_ack_i     in   1          slave ack
//  uart_irq_i   in   1          UART interrupt
//  busy_o       out  1          1 whenever state != S_IDLE
//  timeout_o    out  1          1-cycle pulse when TIMEOUT_CYC expired waiting for IRQ
// BEHAVIOUR
//  Reset: all outputs 0; state=S_INIT; rr pointer=NUM_REQ-1 (so requester 0 wins first); counter=0.
//  Bus cycle rule (every transaction): drive cyc=stb=1 with we/addr/data stable until wb_ack_i=1;
//   the cycle after ack seen, cyc=stb=we=0; then wait for wb_ack_i=0 before any new cycle or S_IDLE.
//   Slave drops ack only after cyc&stb low; issuing a new cycle while ack is high is an error.
//  States:
//   S_INIT      write IER=8'h01 -> on ack S_INIT_REL.   S_INIT_REL: wait ack low -> S_IDLE.
//   S_IDLE      if any req_valid_i: grant = first set bit searching from rr+1 upward modulo NUM_REQ;
//               latch byte and grant index, rr<=grant, -> S_WR_THR. Else stay.
//   S_WR_THR    write THR=latched byte; on ack: req_ready_o[grant] pulses 1 cycle -> S_WR_REL.
//   S_WR_REL    wait ack low; clear counter -> S_WAIT_IRQ.
//   S_WAIT_IRQ  if uart_irq_i -> S_RD_ISR. Else counter++; when counter==TIMEOUT_CYC-1: timeout_o
//               pulse, -> S_RD_ISR. IRQ and expiry same cycle: IRQ wins, no timeout pulse.
//   S_RD_ISR    read ISR (we=0, addr=3); read clears ISR in slave; data discarded -> S_RD_REL on ack.
//   S_RD_REL    wait ack low -> S_IDLE.
//  Latency: request to THR cyc assertion = 1 cycle after sampling in S_IDLE; with a 1-cycle-ack slave
//   one byte costs 7 cycles + IRQ wait. No new grant until previous byte's ISR read completes.
//  Requester contract: req_valid_i and data held until req_ready_o pulse; byte latched at grant,
//   so data changes after grant do not affect the in-flight byte. Withdrawn valid after grant: byte
//   still sent and ready still pulses.
//  Round-robin: after granting k, k has lowest priority next time; single active requester is granted
//   back-to-back. Counter width = clog2(TIMEOUT_CYC+1); no wrap, saturates only via state exit.
//  Async reset mid-transaction: outputs and state return to reset values immediately; INIT reruns.
// TESTING
//  Reset then 1-cycle-ack model -> IER write 8'h01 first, cyc dropped, then idle with busy_o=0.
//  req_valid_i=2'b01, data0=8'hA5; IRQ 20 cycles after THR ack -> THR write A5, ready_o=01 pulse, ISR read.
//  req_valid_i=2'b11 held for 4 bytes -> grants 0,1,0,1; each ready pulse one-hot, bytes in order.
//  No IRQ, TIMEOUT_CYC=16 -> timeout_o single pulse 16 cycles after WAIT_IRQ entry, then ISR read.
//  Slave holding ack 3 cycles after cyc drop -> no new cyc asserted until ack low.
//  rst_ni low during S_WAIT_IRQ -> all outputs 0 asynchronously; after release IER rewritten.

Source files
------------

// File: rtl/nexi_uart_tx_sched.sv
// Wishbone master feeding the nexi UART: round-robin byte arbitration, THR write,
// wait for TX IRQ (with timeout), then ISR read to clear. One byte in flight at a time.
module nexi_uart_tx_sched #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic                   wb_cyc_o,
    output logic                   wb_stb_o,
    output logic                   wb_we_o,
    output logic [2:0]             wb_addr_o,
    output logic [7:0]             wb_data_o,
    input  logic [7:0]             wb_data_i,
    input  logic                   wb_ack_i,
    input  logic                   uart_irq_i,
    output logic                   busy_o,
    output logic                   timeout_o
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [2:0] ADDR_THR = 3'd1;
    localparam logic [2:0] ADDR_IER = 3'd2;
    localparam logic [2:0] ADDR_ISR = 3'd3;

    localparam logic [2:0] S_INIT     = 3'd0;
    localparam logic [2:0] S_INIT_REL = 3'd1;
    localparam logic [2:0] S_IDLE     = 3'd2;
    localparam logic [2:0] S_WR_THR   = 3'd3;
    localparam logic [2:0] S_WR_REL   = 3'd4;
    localparam logic [2:0] S_WAIT_IRQ = 3'd5;
    localparam logic [2:0] S_RD_ISR   = 3'd6;
    localparam logic [2:0] S_RD_REL   = 3'd7;

    logic [2:0]         state_q, state_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [7:0]         byte_q, byte_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cyc_q, cyc_d;
    logic               we_q, we_d;
    logic [2:0]         addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic               timeout_q, timeout_d;
    logic               busy_q, busy_d;

    logic               found;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   cand;
    logic [7:0]         sel_byte;

    // ISR contents are read only to clear the interrupt; the value is not needed.
    logic unused_rd_data;
    assign unused_rd_data = ^wb_data_i;

    // Search starts just above the last grant so the previous winner ranks lowest.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((32'(rr_q) + i) % NUM_REQ);
            if (!found && req_valid_i[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign sel_byte = req_data_i[{grant_idx, 3'b000} +: 8];

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        grant_d   = grant_q;
        byte_d    = byte_q;
        cnt_d     = cnt_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ready_d   = '0;
        timeout_d = 1'b0;

        case (state_q)
            S_INIT: begin
                if (cyc_q && wb_ack_i) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                    state_d = S_INIT_REL;
                end else if (!cyc_q && !wb_ack_i) begin
                    cyc_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = ADDR_IER;
                    wdata_d = 8'h01;
                end
            end
            S_INIT_REL: begin
                if (!wb_ack_i) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (found) begin
                    grant_d = grant_idx;
                    rr_d    = grant_idx;
                    byte_d  = sel_byte;
                    state_d = S_WR_THR;
                    if (!wb_ack_i) begin
                        cyc_d   = 1'b1;
                        we_d    = 1'b1;
                        addr_d  = ADDR_THR;
                        wdata_d = sel_byte;
                    end
                end
            end
            S_WR_THR: begin
                if (cyc_q && wb_ack_i) begin
                    cyc_d            = 1'b0;
                    we_d             = 1'b0;
                    addr_d           = '0;
                    wdata_d          = '0;
                    ready_d[grant_q] = 1'b1;
                    state_d          = S_WR_REL;
                end else if (!cyc_q && !wb_ack_i) begin
                    cyc_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = ADDR_THR;
                    wdata_d = byte_q;
                end
            end
            S_WR_REL: begin
                if (!wb_ack_i) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_IRQ;
                end
            end
            S_WAIT_IRQ: begin
                if (uart_irq_i || (cnt_q == CNT_LAST)) begin
                    timeout_d = !uart_irq_i;
                    state_d   = S_RD_ISR;
                    if (!wb_ack_i) begin
                        cyc_d   = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = ADDR_ISR;
                        wdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RD_ISR: begin
                if (cyc_q && wb_ack_i) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                    state_d = S_RD_REL;
                end else if (!cyc_q && !wb_ack_i) begin
                    cyc_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = ADDR_ISR;
                    wdata_d = '0;
                end
            end
            S_RD_REL: begin
                if (!wb_ack_i) state_d = S_IDLE;
            end
            default: begin
                cyc_d   = 1'b0;
                we_d    = 1'b0;
                addr_d  = '0;
                wdata_d = '0;
                state_d = S_INIT;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_INIT;
            rr_q      <= IDX_W'(NUM_REQ - 1);
            grant_q   <= '0;
            byte_q    <= '0;
            cnt_q     <= '0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ready_q   <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            grant_q   <= grant_d;
            byte_q    <= byte_d;
            cnt_q     <= cnt_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ready_q   <= ready_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_we_o     = we_q;
    assign wb_addr_o   = addr_q;
    assign wb_data_o   = wdata_q;
    assign req_ready_o = ready_q;
    assign timeout_o   = timeout_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_nexi_uart_tx_sched.sv
// Bench for nexi_uart_tx_sched: wishbone slave + UART IRQ model, round-robin reference model
// feeding a scoreboard of expected bus transactions and ready pulses.
module tb_nexi_uart_tx_sched;

    localparam int NUM = 3;
    localparam int TO  = 16;

    typedef struct packed {
        logic       we;
        logic [2:0] addr;
        logic [7:0] data;
    } txn_t;

    logic               clk;
    logic               rst_n;
    logic [NUM-1:0]     req_valid;
    logic [8*NUM-1:0]   req_data;
    logic [NUM-1:0]     req_ready;
    logic               wb_cyc, wb_stb, wb_we;
    logic [2:0]         wb_addr;
    logic [7:0]         wb_wdata, wb_rdata;
    logic               ack, irq, busy, timeout;

    int checks   = 0;
    int failures = 0;

    txn_t       exp_bus[$];
    int         exp_ready[$];
    logic [7:0] pend[NUM][$];
    int         model_rr;
    bit         scramble = 0;
    int         cur_l = 1, cur_h = 0, irq_mode = -2;

    nexi_uart_tx_sched #(.NUM_REQ(NUM), .TIMEOUT_CYC(TO)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_valid_i(req_valid),
        .req_data_i (req_data),
        .req_ready_o(req_ready),
        .wb_cyc_o   (wb_cyc),
        .wb_stb_o   (wb_stb),
        .wb_we_o    (wb_we),
        .wb_addr_o  (wb_addr),
        .wb_data_o  (wb_wdata),
        .wb_data_i  (wb_rdata),
        .wb_ack_i   (ack),
        .uart_irq_i (irq),
        .busy_o     (busy),
        .timeout_o  (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, want);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Reference: requesters are valid exactly while their queue is non-empty, so the grant
    // order is fully determined by queue contents and the round-robin pointer.
    task automatic model_push();
        logic [7:0] mq[NUM][$];
        bit         any;
        int         g;
        logic [7:0] b;
        for (int k = 0; k < NUM; k++) mq[k] = pend[k];
        while (1) begin
            any = 0;
            g   = 0;
            for (int i = 1; i <= NUM; i++) begin
                if (!any && mq[(model_rr + i) % NUM].size() != 0) begin
                    any = 1;
                    g   = (model_rr + i) % NUM;
                end
            end
            if (!any) break;
            b = mq[g].pop_front();
            exp_bus.push_back('{we: 1'b1, addr: 3'd1, data: b});
            exp_bus.push_back('{we: 1'b0, addr: 3'd3, data: 8'h00});
            exp_ready.push_back(g);
            model_rr = g;
        end
    endtask

    // Requester driver: hold byte and valid until the ready pulse, then present the next one.
    initial begin
        req_valid = '0;
        req_data  = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NUM; k++)
                if (req_ready[k] && pend[k].size() != 0) void'(pend[k].pop_front());
            for (int k = 0; k < NUM; k++) begin
                req_valid[k] = (pend[k].size() != 0) && !scramble;
                req_data[8*k +: 8] = (pend[k].size() != 0) ?
                                     (pend[k][0] ^ (scramble ? 8'hFF : 8'h00)) : 8'h00;
            end
        end
    end

    // Monitor: wishbone slave, UART IRQ model and scoreboard checks.
    initial begin : monitor
        bit   prev_cyc;
        int   wait_cnt, hold_left, irq_cnt, since, to_cycle, d;
        bit   to_pending;
        txn_t cap, e;
        ack = 0; irq = 0; wb_rdata = '0;
        prev_cyc = 0; wait_cnt = 0; hold_left = 0; irq_cnt = -1; since = 0;
        to_pending = 0; to_cycle = 0; cap = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                ack = 0; irq = 0; irq_cnt = -1; to_pending = 0;
                prev_cyc = 0; wait_cnt = 0; hold_left = 0;
            end else begin
                chk("stb_eq_cyc", 32'(wb_stb), 32'(wb_cyc));
                since++;
                if (irq_cnt > 0) begin
                    irq_cnt--;
                    if (irq_cnt == 0) irq = 1;
                end
                if (req_ready != '0) begin
                    if (exp_ready.size() == 0) fail("ready_unexpected");
                    else chk("ready_onehot", 32'(req_ready), 32'(1) << exp_ready.pop_front());
                    chk("busy_in_txn", 32'(busy), 32'(1));
                    if (irq_mode == -1) d = -1;
                    else if (irq_mode == -2) d = $urandom_range(1, TO + cur_h + 4);
                    else d = irq_mode;
                    irq_cnt    = d;
                    since      = 0;
                    to_pending = (d < 0) || (d > TO + cur_h);
                    to_cycle   = TO + 1 + cur_h;
                end
                if (timeout) begin
                    chk("timeout_expected", 32'(to_pending), 32'(1));
                    if (to_pending) chk("timeout_cycle", 32'(since), 32'(to_cycle));
                    to_pending = 0;
                end
                if (wb_cyc && !prev_cyc && ack) fail("cyc_while_ack");
                if (wb_cyc && !ack) begin
                    if (!prev_cyc) cap = '{we: wb_we, addr: wb_addr, data: wb_wdata};
                    else chk("bus_stable", 32'({wb_we, wb_addr, wb_wdata}), 32'(cap));
                    wait_cnt++;
                    if (wait_cnt >= cur_l) begin
                        ack       = 1;
                        hold_left = cur_h;
                        wait_cnt  = 0;
                        wb_rdata  = 8'($urandom_range(0, 255));
                        if (exp_bus.size() == 0) fail("txn_unexpected");
                        else begin
                            e = exp_bus.pop_front();
                            chk("bus_we", 32'(wb_we), 32'(e.we));
                            chk("bus_addr", 32'(wb_addr), 32'(e.addr));
                            if (e.we) chk("bus_data", 32'(wb_wdata), 32'(e.data));
                        end
                        if (!wb_we && wb_addr == 3'd3) begin
                            chk("timeout_missing", 32'(to_pending), 32'(0));
                            to_pending = 0;
                            irq        = 0;
                            irq_cnt    = -1;
                        end
                    end
                end else if (!wb_cyc && ack) begin
                    if (hold_left == 0) ack = 0;
                    else hold_left--;
                end
                prev_cyc = wb_cyc;
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst_cyc", 32'(wb_cyc), 32'(0));
        chk("rst_stb", 32'(wb_stb), 32'(0));
        chk("rst_we", 32'(wb_we), 32'(0));
        chk("rst_addr", 32'(wb_addr), 32'(0));
        chk("rst_data", 32'(wb_wdata), 32'(0));
        chk("rst_ready", 32'(req_ready), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_timeout", 32'(timeout), 32'(0));
    endtask

    task automatic wait_done(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk);
            if (exp_bus.size() == 0 && exp_ready.size() == 0) break;
        end
        if (i >= budget) begin
            fail("drain_timeout");
            exp_bus.delete();
            exp_ready.delete();
        end
        repeat (cur_h + 4) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'(0));
        chk("idle_cyc", 32'(wb_cyc), 32'(0));
    endtask

    task automatic wait_out(input int sel, input string name);
        int i;
        for (i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if (sel == 0 && wb_cyc && wb_addr == 3'd1) break;
            if (sel == 1 && req_ready != '0) break;
        end
        if (i >= 500) fail(name);
    endtask

    task automatic run_phase(input int l, input int h, input int mode,
                             input int c0, input int c1, input int c2,
                             input int fixed, input bit scr);
        int cnt[NUM];
        cur_l = l; cur_h = h; irq_mode = mode;
        cnt[0] = c0; cnt[1] = c1; cnt[2] = c2;
        for (int k = 0; k < NUM; k++)
            for (int j = 0; j < cnt[k]; j++)
                pend[k].push_back(fixed >= 0 ? 8'(fixed) : 8'($urandom_range(0, 255)));
        model_push();
        if (scr) begin
            wait_out(0, "thr_cyc_wait");
            scramble = 1;
            wait_out(1, "ready_wait");
            scramble = 0;
        end
        wait_done(3000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1;
        irq_mode = -2;
        #1 rst_n = 0;
        #1 check_reset_outputs();
        model_rr = NUM - 1;
        exp_bus.push_back('{we: 1'b1, addr: 3'd2, data: 8'h01});
        repeat (2) @(negedge clk);
        rst_n = 1;
        wait_done(200);

        run_phase(1, 0, 10, 1, 0, 0, 8'hA5, 0);
        run_phase(1, 0, -2, 2, 2, 0, -1, 0);
        run_phase(1, 0, -1, 0, 2, 1, -1, 0);
        run_phase(2, 3, -2, 1, 1, 1, -1, 0);
        run_phase(1, 0, TO, 0, 0, 1, -1, 0);
        run_phase(1, 0, TO + 1, 1, 0, 0, -1, 0);
        run_phase(1, 3, TO + 3, 0, 1, 0, -1, 0);
        run_phase(1, 1, -1, 1, 0, 1, -1, 0);
        run_phase(1, 0, -2, 1, 2, 0, -1, 1);
        for (int p = 0; p < 6; p++)
            run_phase($urandom_range(1, 3), $urandom_range(0, 3), -2,
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), -1, 0);

        // Reset while the byte is waiting for its IRQ.
        cur_l = 1; cur_h = 0; irq_mode = -1;
        pend[1].push_back(8'h3C);
        model_push();
        wait_out(1, "ready_wait_rst");
        repeat (5) @(posedge clk);
        #3 rst_n = 0;
        #1 check_reset_outputs();
        exp_bus.delete();
        exp_ready.delete();
        model_rr = NUM - 1;
        exp_bus.push_back('{we: 1'b1, addr: 3'd2, data: 8'h01});
        repeat (2) @(negedge clk);
        rst_n = 1;
        wait_done(200);
        run_phase(1, 0, -2, 1, 1, 1, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
